// File: rtl/add_arbiter.sv
// Round-robin sequencer sharing one external 8-bit adder between two requesters.
// 16-bit adds run as two byte passes, low byte first, with the carry held in a register.
module add_arbiter #(
  parameter logic RR_INIT = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [15:0] req0_a,
  input  logic [15:0] req0_b,
  input  logic        req0_cin,
  input  logic        req0_wide,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [15:0] req1_a,
  input  logic [15:0] req1_b,
  input  logic        req1_cin,
  input  logic        req1_wide,
  output logic [7:0]  add_a,
  output logic [7:0]  add_b,
  output logic        add_cin,
  input  logic [7:0]  add_sum,
  input  logic        add_cout,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [15:0] rsp_sum,
  output logic        rsp_cout,
  output logic        rsp_ovf
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LO   = 2'd1;
  localparam logic [1:0] HI   = 2'd2;
  localparam logic [1:0] RSP  = 2'd3;

  logic [1:0]  state;
  logic        prio;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic        op_cin;
  logic        op_wide;
  logic        op_id;
  logic        carry;
  logic        grant0;
  logic        grant1;
  logic        ovf_lo;
  logic        ovf_hi;

  // A lone requester wins outright; the priority bit only breaks ties.
  always_comb begin
    grant0 = req0_valid && (!req1_valid || (prio == 1'b0));
    grant1 = req1_valid && (!req0_valid || (prio == 1'b1));
  end

  assign req0_ready = (state == IDLE) && grant0;
  assign req1_ready = (state == IDLE) && grant1;
  assign rsp_valid  = (state == RSP);
  assign rsp_id     = op_id;

  always_comb begin
    add_a   = 8'h00;
    add_b   = 8'h00;
    add_cin = 1'b0;
    case (state)
      LO: begin
        add_a   = op_a[7:0];
        add_b   = op_b[7:0];
        add_cin = op_cin;
      end
      HI: begin
        add_a   = op_a[15:8];
        add_b   = op_b[15:8];
        add_cin = carry;
      end
      default: ;
    endcase
  end

  // Signed overflow: operands agree in sign but the result sign differs.
  assign ovf_lo = (op_a[7] == op_b[7]) && (add_sum[7] != op_a[7]);
  assign ovf_hi = (op_a[15] == op_b[15]) && (add_sum[7] != op_a[15]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      prio     <= RR_INIT;
      op_a     <= 16'h0000;
      op_b     <= 16'h0000;
      op_cin   <= 1'b0;
      op_wide  <= 1'b0;
      op_id    <= 1'b0;
      carry    <= 1'b0;
      rsp_sum  <= 16'h0000;
      rsp_cout <= 1'b0;
      rsp_ovf  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant0 || grant1) begin
            op_a    <= grant1 ? req1_a : req0_a;
            op_b    <= grant1 ? req1_b : req0_b;
            op_cin  <= grant1 ? req1_cin : req0_cin;
            op_wide <= grant1 ? req1_wide : req0_wide;
            op_id   <= grant1;
            state   <= LO;
          end
        end
        LO: begin
          rsp_sum[7:0] <= add_sum;
          carry        <= add_cout;
          if (op_wide) begin
            state <= HI;
          end else begin
            rsp_sum[15:8] <= 8'h00;
            rsp_cout      <= add_cout;
            rsp_ovf       <= ovf_lo;
            state         <= RSP;
          end
        end
        HI: begin
          rsp_sum[15:8] <= add_sum;
          rsp_cout      <= add_cout;
          rsp_ovf       <= ovf_hi;
          state         <= RSP;
        end
        default: begin
          if (rsp_ready) begin
            prio  <= ~op_id;
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_add_arbiter.sv
// Bench for add_arbiter: table vectors, hand-written corner sequences and
// randomized requests checked against an arithmetic reference model.
module tb_add_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req0_ready, req0_cin, req0_wide;
  logic [15:0] req0_a, req0_b;
  logic        req1_valid, req1_ready, req1_cin, req1_wide;
  logic [15:0] req1_a, req1_b;
  logic [7:0]  add_a, add_b, add_sum;
  logic        add_cin, add_cout;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_cout, rsp_ovf;
  logic [15:0] rsp_sum;

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  // The shared ripple-carry adder lives outside the DUT.
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {8'h00, add_cin};

  add_arbiter #(.RR_INIT(1'b0)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_cin(req0_cin), .req0_wide(req0_wide),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_cin(req1_cin), .req1_wide(req1_wide),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_sum(add_sum), .add_cout(add_cout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_sum(rsp_sum),
    .rsp_cout(rsp_cout), .rsp_ovf(rsp_ovf)
  );

  typedef struct {
    logic        id;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        wide;
    logic [15:0] e_sum;
    logic        e_cout;
    logic        e_ovf;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Reference: plain integer arithmetic, overflow as result outside signed range.
  task automatic ref_add(input logic [15:0] a, input logic [15:0] b, input logic cin,
                         input logic wide, output logic [15:0] s, output logic co,
                         output logic ov);
    int unsigned u;
    int sa, sb, ss;
    if (wide) begin
      u  = 32'(a) + 32'(b) + 32'(cin);
      s  = u[15:0];
      co = (u > 32'hFFFF);
      sa = $signed(a);
      sb = $signed(b);
      ss = sa + sb + int'(cin);
      ov = (ss > 32767) || (ss < -32768);
    end else begin
      u  = 32'(a[7:0]) + 32'(b[7:0]) + 32'(cin);
      s  = {8'h00, u[7:0]};
      co = (u > 32'hFF);
      sa = $signed(a[7:0]);
      sb = $signed(b[7:0]);
      ss = sa + sb + int'(cin);
      ov = (ss > 127) || (ss < -128);
    end
  endtask

  task automatic set_req(input logic id, input logic [15:0] a, input logic [15:0] b,
                         input logic cin, input logic wide, input logic v);
    if (id) begin
      req1_a = a; req1_b = b; req1_cin = cin; req1_wide = wide; req1_valid = v;
    end else begin
      req0_a = a; req0_b = b; req0_cin = cin; req0_wide = wide; req0_valid = v;
    end
  endtask

  // Called at a negedge; returns at a negedge. Completes the response handshake
  // only when rsp_ready is already high.
  task automatic run_op(input logic id, input logic [15:0] a, input logic [15:0] b,
                        input logic cin, input logic wide,
                        output logic [15:0] s, output logic co, output logic ov,
                        output logic rid, output int lat,
                        output logic [16:0] lo_bus, output logic [16:0] hi_bus);
    bit acc = 0;
    bit got = 0;
    lat = 0; s = 16'h0; co = 0; ov = 0; rid = 0; lo_bus = 17'h0; hi_bus = 17'h0;
    set_req(id, a, b, cin, wide, 1'b1);
    for (int i = 0; i < 20 && !acc; i++) begin
      #1;
      if (id ? req1_ready : req0_ready) acc = 1;
      else @(negedge clk);
    end
    if (!acc) begin
      check("accept_timeout", 0, 1);
      set_req(id, a, b, cin, wide, 1'b0);
      return;
    end
    @(posedge clk);
    #1 set_req(id, a, b, cin, wide, 1'b0);
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      lat++;
      if (lat == 1) lo_bus = {add_a, add_b, add_cin};
      if (lat == 2) hi_bus = {add_a, add_b, add_cin};
      if (rsp_valid) got = 1;
    end
    if (!got) begin
      check("rsp_timeout", 0, 1);
      return;
    end
    s = rsp_sum; co = rsp_cout; ov = rsp_ovf; rid = rsp_id;
    if (rsp_ready) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  logic [15:0] s, e_s, hold_sum;
  logic        co, ov, rid, e_co, e_ov;
  logic [16:0] lo_bus, hi_bus;
  int          lat;

  initial begin
    vecs[0] = '{1'b0, 16'h00F0, 16'h0020, 1'b0, 1'b0, 16'h0010, 1'b1, 1'b0};
    vecs[1] = '{1'b0, 16'h007F, 16'h0001, 1'b0, 1'b0, 16'h0080, 1'b0, 1'b1};
    vecs[2] = '{1'b1, 16'h8000, 16'h8000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b1};
    vecs[3] = '{1'b1, 16'hFFFF, 16'h0000, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 16'hAB80, 16'hCD80, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[5] = '{1'b1, 16'h5505, 16'h6603, 1'b1, 1'b0, 16'h0009, 1'b0, 1'b0};

    rst_n = 1'b0; rsp_ready = 1'b1;
    set_req(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
    set_req(1'b1, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
    #1;
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_rsp_sum", rsp_sum, 0);
    check("reset_rsp_id", rsp_id, 0);
    check("reset_cout_ovf", {rsp_cout, rsp_ovf}, 0);
    check("reset_add_bus", {add_a, add_b, add_cin}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      run_op(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].wide,
             s, co, ov, rid, lat, lo_bus, hi_bus);
      $display("vec %0d id=%0d a=%h b=%h cin=%0d wide=%0d -> sum=%h cout=%0d ovf=%0d lat=%0d",
               i, vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].wide, s, co, ov, lat);
      check($sformatf("vec%0d_sum", i), s, vecs[i].e_sum);
      check($sformatf("vec%0d_cout", i), co, vecs[i].e_cout);
      check($sformatf("vec%0d_ovf", i), ov, vecs[i].e_ovf);
      check($sformatf("vec%0d_id", i), rid, vecs[i].id);
      check($sformatf("vec%0d_latency", i), lat, vecs[i].wide ? 3 : 2);
    end

    // Wide carry chain: byte passes and the carry handed between them.
    run_op(1'b1, 16'h12FF, 16'h0001, 1'b0, 1'b1, s, co, ov, rid, lat, lo_bus, hi_bus);
    $display("chain sum=%h cout=%0d ovf=%0d lo=%h hi=%h", s, co, ov, lo_bus, hi_bus);
    check("chain_lo_bus", lo_bus, {8'hFF, 8'h01, 1'b0});
    check("chain_hi_bus", hi_bus, {8'h12, 8'h00, 1'b1});
    check("chain_sum", {s, co, ov, rid}, {16'h1300, 1'b0, 1'b0, 1'b1});
    check("chain_idle_bus", {add_a, add_b, add_cin}, 0);

    // Randomized requests against the reference model.
    for (int i = 0; i < 40; i++) begin
      logic        id, cin, wide;
      logic [15:0] a, b;
      id = 1'($urandom); cin = 1'($urandom); wide = 1'($urandom);
      a = 16'($urandom); b = 16'($urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      ref_add(a, b, cin, wide, e_s, e_co, e_ov);
      run_op(id, a, b, cin, wide, s, co, ov, rid, lat, lo_bus, hi_bus);
      $display("rnd %0d id=%0d a=%h b=%h cin=%0d wide=%0d -> sum=%h cout=%0d ovf=%0d",
               i, id, a, b, cin, wide, s, co, ov);
      check("rnd_result", {s, co, ov, rid}, {e_s, e_co, e_ov, id});
      check("rnd_latency", lat, wide ? 3 : 2);
    end

    // Backpressure: response held, new request must wait.
    rsp_ready = 1'b0;
    run_op(1'b0, 16'h0033, 16'h0044, 1'b0, 1'b0, s, co, ov, rid, lat, lo_bus, hi_bus);
    hold_sum = rsp_sum;
    check("bp_sum", hold_sum, 16'h0077);
    set_req(1'b1, 16'h0001, 16'h0001, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      $display("bp cycle %0d valid=%0d sum=%h r0=%0d r1=%0d", i, rsp_valid, rsp_sum,
               req0_ready, req1_ready);
      check("bp_hold", {rsp_valid, rsp_sum, rsp_id, req0_ready, req1_ready},
            {1'b1, hold_sum, 1'b0, 1'b0, 1'b0});
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_release", {rsp_valid, req1_ready}, {1'b0, 1'b1});
    set_req(1'b1, 16'h0001, 16'h0001, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check("dropped_valid_no_accept", rsp_valid, 0);

    // Reset during the high pass of a wide op from requester 1.
    set_req(1'b1, 16'h4321, 16'h1234, 1'b1, 1'b1, 1'b1);
    #1 check("rst_test_accept", req1_ready, 1);
    @(posedge clk);
    #1 set_req(1'b1, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check("rst_test_in_hi", add_a, 8'h43);
    #2 rst_n = 1'b0;
    #1;
    $display("async reset: valid=%0d sum=%h id=%0d add=%h", rsp_valid, rsp_sum, rsp_id,
             {add_a, add_b, add_cin});
    check("rst_async_rsp", {rsp_valid, rsp_sum, rsp_id, rsp_cout, rsp_ovf}, 0);
    check("rst_async_bus", {add_a, add_b, add_cin}, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    begin
      bit stale = 0;
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        if (rsp_valid) stale = 1;
      end
      check("no_stale_rsp", stale, 0);
    end

    // Contention: both valid, priority back at RR_INIT, grants alternate.
    begin
      int  grants[$];
      bit  prev_any = 0;
      set_req(1'b0, 16'h0001, 16'h0002, 1'b0, 1'b0, 1'b1);
      set_req(1'b1, 16'h0003, 16'h0004, 1'b0, 1'b0, 1'b1);
      #1;
      for (int i = 0; i < 14; i++) begin
        check("never_both_ready", req0_ready && req1_ready, 0);
        if (req0_ready || req1_ready) begin
          check("ready_one_cycle", prev_any, 0);
          grants.push_back(int'(req1_ready));
          $display("grant to %0d at cycle %0d", req1_ready, i);
        end
        prev_any = req0_ready || req1_ready;
        @(negedge clk);
        #1;
      end
      set_req(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
      set_req(1'b1, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
      check("grant_count_ge4", grants.size() >= 4, 1);
      if (grants.size() >= 4) begin
        check("grant_order", {grants[0][0], grants[1][0], grants[2][0], grants[3][0]},
              4'b0101);
      end
    end

    repeat (4) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
